stream_demux1n: RTL and testbench

//  1-to-N packet stream demultiplexer: routes each valid/ready packet on the input to one of N outputs.
//  - Selection is taken on the first beat of each packet and held until that packet's last beat.
//  - One registered stage sits between the input and the outputs.
//  - Intended as the dispatch end opposite the gate-level 2:1 mux datapath in the ex1_mux exercise set.

---
 rtl/stream_demux1n_pkg.sv | 10 +
 rtl/demux_out_reg.sv | 60 ++++++
 rtl/stream_demux1n.sv | 112 +++++++++++
 tb/tb_stream_demux1n.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/stream_demux1n_pkg.sv
// Shared definitions for the 1-to-N packet stream demultiplexer: FSM states and counter width.
package stream_demux1n_pkg;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;
endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register carrying payload, last flag and destination channel.
module demux_out_reg #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic [SEL_W-1:0]  push_ch,
  input  logic              drain_ready,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [SEL_W-1:0]  ch
);
  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  ch_q, ch_d;

  // Draining and refilling on the same edge keeps the entry full with no bubble.
  assign push_ready = !full_q || drain_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    ch_d   = ch_q;
    if (push_valid && push_ready) begin
      full_d = 1'b1;
      data_d = push_data;
      last_d = push_last;
      ch_d   = push_ch;
    end else if (drain_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
      ch_q   <= ch_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign last = last_q;
  assign ch   = ch_q;
endmodule

// File: rtl/stream_demux1n.sv
// 1-to-N packet stream demultiplexer with one registered output stage.
// Optional DEMUX_DROP_CNT_EN builds a saturating counter of discarded beats.
module stream_demux1n
  import stream_demux1n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int SEL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [N_OUT-1:0]      out_valid,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam logic [SEL_W:0] N_OUT_V = (SEL_W+1)'(N_OUT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             accept, fwd, in_rng;
  logic             push_ready, drain_ready;
  logic             reg_full;
  logic [SEL_W-1:0] reg_ch;
  logic [SEL_W-1:0] push_ch;

  assign in_rng   = {1'b0, in_sel} < N_OUT_V;
  assign in_ready = rst_n && ((state_q == DROP) || push_ready);
  assign accept   = in_valid && in_ready;
  assign fwd      = accept && ((state_q == ROUTE) || (state_q == IDLE && in_rng));
  assign push_ch  = (state_q == IDLE) ? in_sel : sel_q;

  always_comb begin
    drain_ready = 1'b0;
    out_valid   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (reg_ch == SEL_W'(i)) begin
        drain_ready  = out_ready[i];
        out_valid[i] = reg_full;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (accept) begin
        if (in_rng) begin
          sel_d = in_sel;
          if (!in_last) state_d = ROUTE;
        end else if (!in_last) begin
          state_d = DROP;
        end
      end
      ROUTE, DROP: if (accept && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  demux_out_reg #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (fwd),
    .push_ready  (push_ready),
    .push_data   (in_data),
    .push_last   (in_last),
    .push_ch     (push_ch),
    .drain_ready (drain_ready),
    .full        (reg_full),
    .data        (out_data),
    .last        (out_last),
    .ch          (reg_ch)
  );

`ifdef DEMUX_DROP_CNT_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop = accept && !fwd;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_demux1n.sv
// Directed, table-driven bench for stream_demux1n (N_OUT=2, DATA_W=8, SEL_W=4).
module tb_stream_demux1n;
`ifdef DEMUX_DROP_CNT_EN
  localparam logic [15:0] DROP_EN = 16'd1;
`else
  localparam logic [15:0] DROP_EN = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [3:0]  in_sel;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  stream_demux1n #(.DATA_W(8), .N_OUT(2), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle; expected values are those seen before that cycle's edge.
  typedef struct {
    logic r, v; logic [7:0] d; logic l; logic [3:0] s; logic [1:0] ordy;
    logic ir; logic [1:0] ov; logic [7:0] od; logic ol; logic [15:0] dc; logic cd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, v, input logic [7:0] d, input logic l, input logic [3:0] s,
                     input logic [1:0] ordy, input logic ir, input logic [1:0] ov,
                     input logic [7:0] od, input logic ol, input logic [15:0] dc, input logic cd);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.l = l; x.s = s; x.ordy = ordy;
    x.ir = ir; x.ov = ov; x.od = od; x.ol = ol; x.dc = dc; x.cd = cd;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, input logic [7:0] d, input logic l, input logic [3:0] s,
                       input logic [1:0] ordy);
    rst_n = r; in_valid = v; in_data = d; in_last = l; in_sel = s; out_ready = ordy;
  endtask

  initial begin
    //   r  v  data   l  sel   ordy   | ir ov     od     ol dc  cd
    // reset held 3 cycles with in_valid high
    add(0, 1, 8'h11, 0, 4'd0, 2'b11,  0, 2'b00, 8'h00, 0, 0, 1);
    add(0, 1, 8'h11, 0, 4'd0, 2'b11,  0, 2'b00, 8'h00, 0, 0, 1);
    add(0, 1, 8'h11, 0, 4'd0, 2'b11,  0, 2'b00, 8'h00, 0, 0, 1);
    // single beat to ch1
    add(1, 1, 8'hA5, 1, 4'd1, 2'b11,  1, 2'b00, 8'h00, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b10, 8'hA5, 1, 0, 1);
    // 4-beat packet to ch0, in_sel toggling after the first beat
    add(1, 1, 8'h10, 0, 4'd0, 2'b11,  1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 1, 8'h11, 0, 4'd1, 2'b11,  1, 2'b01, 8'h10, 0, 0, 1);
    add(1, 1, 8'h12, 0, 4'd0, 2'b11,  1, 2'b01, 8'h11, 0, 0, 1);
    add(1, 1, 8'h13, 1, 4'd1, 2'b11,  1, 2'b01, 8'h12, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b01, 8'h13, 1, 0, 1);
    // backpressure on ch0 for 5 cycles mid-packet
    add(1, 1, 8'h20, 0, 4'd0, 2'b11,  1, 2'b00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 8'h21, 0, 4'd1, 2'b10, 0, 2'b01, 8'h20, 0, 0, 1);
    add(1, 1, 8'h21, 0, 4'd1, 2'b11,  1, 2'b01, 8'h20, 0, 0, 1);
    add(1, 1, 8'h22, 0, 4'd1, 2'b11,  1, 2'b01, 8'h21, 0, 0, 1);
    add(1, 1, 8'h23, 1, 4'd1, 2'b11,  1, 2'b01, 8'h22, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b01, 8'h23, 1, 0, 1);
    // 3-beat packet to out-of-range sel 3, then a legal packet
    add(1, 1, 8'h30, 0, 4'd3, 2'b11,  1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 1, 8'h31, 0, 4'd0, 2'b00,  1, 2'b00, 8'h00, 0, 1, 0);
    add(1, 1, 8'h32, 1, 4'd0, 2'b11,  1, 2'b00, 8'h00, 0, 2, 0);
    add(1, 1, 8'h40, 1, 4'd0, 2'b11,  1, 2'b00, 8'h00, 0, 3, 0);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b01, 8'h40, 1, 3, 1);
    // single-beat drop at max sel, then a beat to ch1
    add(1, 1, 8'h50, 1, 4'd15, 2'b11, 1, 2'b00, 8'h00, 0, 3, 0);
    add(1, 1, 8'h51, 1, 4'd1, 2'b11,  1, 2'b00, 8'h00, 0, 4, 0);
    // new packet while old last beat is stuck on ch1: in_ready follows ch1
    add(1, 1, 8'h52, 1, 4'd0, 2'b01,  0, 2'b10, 8'h51, 1, 4, 1);
    add(1, 1, 8'h52, 1, 4'd0, 2'b11,  1, 2'b10, 8'h51, 1, 4, 1);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b01, 8'h52, 1, 4, 1);
    // reset after beat 2 of a 4-beat ch1 packet
    add(1, 1, 8'h60, 0, 4'd1, 2'b11,  1, 2'b00, 8'h00, 0, 4, 0);
    add(1, 1, 8'h61, 0, 4'd0, 2'b11,  1, 2'b10, 8'h60, 0, 4, 1);
    add(0, 1, 8'h62, 0, 4'd0, 2'b11,  0, 2'b10, 8'h61, 0, 4, 1);
    add(1, 1, 8'h70, 1, 4'd0, 2'b11,  1, 2'b00, 8'h00, 0, 0, 1);
    add(1, 0, 8'h00, 0, 4'd0, 2'b11,  1, 2'b01, 8'h70, 1, 0, 1);

    drive(0, 0, 8'h00, 0, 4'd0, 2'b11);
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].ordy);
      #1;
      check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("row%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].dc * DROP_EN));
      if (vecs[i].cd) begin
        check($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
        check($sformatf("row%0d out_last", i), 32'(out_last), 32'(vecs[i].ol));
      end
    end

    // Back-to-back 8-beat burst to ch1: one beat per cycle, one cycle latency.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1, 1, 8'h80 + 8'(k), k == 7, (k == 0) ? 4'd1 : 4'd0, 2'b11);
      #1;
      check($sformatf("burst%0d in_ready", k), 32'(in_ready), 32'd1);
      if (k > 0) begin
        check($sformatf("burst%0d out_valid", k), 32'(out_valid), 32'h2);
        check($sformatf("burst%0d out_data", k), 32'(out_data), 32'h80 + 32'(k - 1));
        check($sformatf("burst%0d out_last", k), 32'(out_last), 32'd0);
      end
    end
    @(negedge clk);
    drive(1, 0, 8'h00, 0, 4'd0, 2'b11);
    #1;
    check("burst_end out_valid", 32'(out_valid), 32'h2);
    check("burst_end out_data", 32'(out_data), 32'h87);
    check("burst_end out_last", 32'(out_last), 32'd1);
    @(negedge clk);
    #1;
    check("burst_drained out_valid", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
